tmds_serializer: RTL and testbench
==================================

TMDS_SERIALIZER -- requirements
Module: tmds_serializer

Interface
REQ-001 Parameter: IDLE_WORD, default 10'b1101010100, 10-bit word sent when no valid word is offered at a load slot (the c1=0/c0=0 control token).
REQ-002 Port: clk  input  1  bit clock, 10x pixel rate, all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: word_in  input  10  encoded TMDS word from the encoder; bit 0 is transmitted first.
REQ-005 Port: word_valid  input  1  word_in holds a word to send.
REQ-006 Port: word_ready  output  1  load slot; word_in is consumed on this clk edge.
REQ-007 Port: clr_underrun  input  1  synchronous clear of the underrun status.
REQ-008 Port: sout  output  1  serial TMDS bit stream.
REQ-009 Port: frame  output  1  high while sout carries bit 0 of a word.
REQ-010 Port: underrun  output  1  sticky flag: at least one load slot had no valid word.
REQ-011 Port: underrun_count  output  8  saturating count of underrun slots (see Configuration).

Function
REQ-012 Internal state SHALL be a 10-bit shift register shreg and a 4-bit bit counter bit_cnt counting 0..9.
REQ-013 sout SHALL equal shreg[0]; frame SHALL equal (bit_cnt == 0); both are direct register decodes with no combinational path from inputs.
REQ-014 word_ready SHALL be high exactly when bit_cnt == 9, independent of word_valid: one cycle in every 10.
REQ-015 When bit_cnt < 9: shreg <= {1'b0, shreg[9:1]}, bit_cnt <= bit_cnt + 1.
REQ-016 When bit_cnt == 9: bit_cnt <= 0; shreg <= word_in if word_valid, else IDLE_WORD.
REQ-017 Latency: a word accepted at edge N SHALL appear as bit 0 on sout in the cycle after edge N, with frame high; bit k follows in cycle N+1+k.
REQ-018 word_in/word_valid SHALL be ignored on all cycles where word_ready is low; holding them stable is not required.
REQ-019 Underrun: a load slot with word_valid=0 SHALL set underrun on the same edge; underrun stays high until cleared.
REQ-020 clr_underrun=1 SHALL clear underrun on the next edge; if an underrun slot coincides with clr_underrun, set wins (underrun=1).
REQ-021 bit_cnt SHALL never take values 10..15. Any such value, if it occurs, SHALL be treated as 9 on the next edge (load and wrap to 0).

Reset
REQ-022 While rst_n=0: shreg=IDLE_WORD, bit_cnt=0, underrun=0, underrun_count=0. Hence sout=IDLE_WORD[0], frame=1, word_ready=0.
REQ-023 Reset asserted mid-word SHALL abort the word immediately (asynchronously). After release, the first full IDLE_WORD is sent, then the first load slot follows 9 edges after release.

Configuration
REQ-024 Macro TMDS_SERIALIZER_UNDERRUN_CNT_EN defined: underrun_count SHALL increment on each underrun slot, saturate at 255, and clear on clr_underrun. If an underrun coincides with clr_underrun, the next value SHALL be 1.
REQ-025 Macro undefined: underrun_count SHALL be tied to 8'd0 and the counter logic SHALL be absent. All other behaviour is unchanged.

Verification
REQ-026 Release reset, word_valid=0 -> sout sends 0,0,1,0,1,0,1,0,1,1 (IDLE_WORD LSB first) with frame high on the first bit; word_ready pulses 9 edges after release; underrun=1 after that slot.
REQ-027 Offer 10'b1010101011 continuously with word_valid=1 -> sout repeats 1,1,0,1,0,1,0,1,0,1; word_ready period is exactly 10 cycles; underrun stays 0.
REQ-028 Alternate words 10'h3FF and 10'h000 on successive slots -> ten 1s then ten 0s with no glitch at the boundary; frame marks each first bit.
REQ-029 Three consecutive slots with word_valid=0, and the macro defined -> underrun_count=3. Assert clr_underrun on a fourth underrun slot -> underrun=1, underrun_count=1. Without the macro -> underrun_count stays 0.
REQ-030 Assert rst_n=0 while bit_cnt=5 of word 10'h2AA -> sout=IDLE_WORD[0] and frame=1 immediately. After release, the REQ-026 sequence repeats.

Source files
------------

// File: rtl/tmds_serializer.sv
// 10:1 TMDS serializer, LSB first, with sticky underrun flag and idle-token fill.
// Define TMDS_SERIALIZER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module tmds_serializer #(
  parameter logic [9:0] IDLE_WORD = 10'b1101010100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  input  logic       clr_underrun,
  output logic       sout,
  output logic       frame,
  output logic       underrun,
  output logic [7:0] underrun_count
);

  logic [9:0] r_shreg;
  logic [9:0] w_shreg_d;
  logic [3:0] r_bit_cnt;
  logic [3:0] w_bit_cnt_d;
  logic       r_underrun;
  logic       w_underrun_d;
  logic       w_load;
  logic       w_underrun_slot;

  // Out-of-range counts (10..15) behave as the load slot so the counter self-recovers.
  assign w_load          = (r_bit_cnt >= 4'd9);
  assign w_underrun_slot = w_load & ~word_valid;

  always_comb begin
    w_shreg_d   = {1'b0, r_shreg[9:1]};
    w_bit_cnt_d = r_bit_cnt + 4'd1;
    if (w_load) begin
      w_bit_cnt_d = 4'd0;
      w_shreg_d   = word_valid ? word_in : IDLE_WORD;
    end
  end

  // Set wins over clear when an underrun slot coincides with clr_underrun.
  assign w_underrun_d = w_underrun_slot | (r_underrun & ~clr_underrun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= IDLE_WORD;
      r_bit_cnt  <= 4'd0;
      r_underrun <= 1'b0;
    end else begin
      r_shreg    <= w_shreg_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_underrun <= w_underrun_d;
    end
  end

`ifdef TMDS_SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_count;
  logic [7:0] w_underrun_count_d;

  always_comb begin
    w_underrun_count_d = r_underrun_count;
    if (clr_underrun) begin
      w_underrun_count_d = w_underrun_slot ? 8'd1 : 8'd0;
    end else if (w_underrun_slot && (r_underrun_count != 8'd255)) begin
      w_underrun_count_d = r_underrun_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_count <= 8'd0;
    end else begin
      r_underrun_count <= w_underrun_count_d;
    end
  end

  assign underrun_count = r_underrun_count;
`else
  assign underrun_count = 8'd0;
`endif

  assign sout       = r_shreg[0];
  assign frame      = (r_bit_cnt == 4'd0);
  assign word_ready = w_load;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed self-checking bench for tmds_serializer: idle fill, data words, underrun, async reset.
module tb_tmds_serializer;

  logic       clk;
  logic       rst_n;
  logic [9:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       clr_underrun;
  logic       sout;
  logic       frame;
  logic       underrun;
  logic [7:0] underrun_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [9:0] IdleWord = 10'b1101010100;
  localparam logic [9:0] WordA    = 10'b1010101011;
  localparam logic [9:0] WordB    = 10'h2AA;

  tmds_serializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .clr_underrun   (clr_underrun),
    .sout           (sout),
    .frame          (frame),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef TMDS_SERIALIZER_UNDERRUN_CNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts on the cycle showing bit 0 of cur; checks all ten bits and offers the next word
  // at the load slot. Non-slot cycles carry random junk that must be ignored.
  task automatic send_word(input logic [9:0] cur, input logic nxt_valid,
                           input logic [9:0] nxt_word, input int clr_k);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("sout[%0d]", k), 32'(sout), 32'(cur[k]));
      check_eq($sformatf("frame[%0d]", k), 32'(frame), 32'(k == 0));
      check_eq($sformatf("ready[%0d]", k), 32'(word_ready), 32'(k == 9));
      clr_underrun = (k == clr_k);
      if (k == 9) begin
        word_in    = nxt_word;
        word_valid = nxt_valid;
      end else begin
        word_in    = 10'($urandom);
        word_valid = 1'($urandom);
      end
      tick();
    end
    clr_underrun = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    word_in      = 10'h000;
    word_valid   = 1'b0;
    clr_underrun = 1'b0;
    repeat (3) tick();

    check_eq("rst_sout", 32'(sout), 32'(IdleWord[0]));
    check_eq("rst_frame", 32'(frame), 32'd1);
    check_eq("rst_ready", 32'(word_ready), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_count", 32'(underrun_count), 32'd0);

    rst_n = 1'b1;
    // First slot empty: idle fill and underrun set.
    send_word(IdleWord, 1'b0, 10'h155, -1);
    check_eq("first_underrun", 32'(underrun), 32'd1);
    check_eq("first_count", 32'(underrun_count), exp_cnt(1));

    // Clear mid-word, then stream WordA.
    send_word(IdleWord, 1'b1, WordA, 0);
    check_eq("clr_underrun", 32'(underrun), 32'd0);
    check_eq("clr_count", 32'(underrun_count), 32'd0);
    send_word(WordA, 1'b1, WordA, -1);
    send_word(WordA, 1'b1, 10'h3FF, -1);
    check_eq("stream_underrun", 32'(underrun), 32'd0);

    // All-ones / all-zeros alternation, then three empty slots.
    send_word(10'h3FF, 1'b1, 10'h000, -1);
    send_word(10'h000, 1'b1, 10'h3FF, -1);
    send_word(10'h3FF, 1'b0, 10'h3FF, -1);
    send_word(IdleWord, 1'b0, 10'h000, -1);
    send_word(IdleWord, 1'b0, 10'h000, -1);
    check_eq("three_underrun", 32'(underrun), 32'd1);
    check_eq("three_count", 32'(underrun_count), exp_cnt(3));

    // Clear coincides with a fourth empty slot: set wins.
    send_word(IdleWord, 1'b0, 10'h000, 9);
    check_eq("coinc_underrun", 32'(underrun), 32'd1);
    check_eq("coinc_count", 32'(underrun_count), exp_cnt(1));

    // Reset in the middle of WordB.
    send_word(IdleWord, 1'b1, WordB, -1);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("wb_sout[%0d]", k), 32'(sout), 32'(WordB[k]));
      word_in    = 10'($urandom);
      word_valid = 1'($urandom);
      tick();
    end
    check_eq("wb_sout[5]", 32'(sout), 32'(WordB[5]));
    check_eq("wb_frame[5]", 32'(frame), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_sout", 32'(sout), 32'(IdleWord[0]));
    check_eq("abort_frame", 32'(frame), 32'd1);
    check_eq("abort_ready", 32'(word_ready), 32'd0);
    check_eq("abort_underrun", 32'(underrun), 32'd0);
    check_eq("abort_count", 32'(underrun_count), 32'd0);
    word_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    send_word(IdleWord, 1'b0, 10'h000, -1);
    check_eq("rerun_underrun", 32'(underrun), 32'd1);
    check_eq("rerun_count", 32'(underrun_count), exp_cnt(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
